bullet_pool: RTL and testbench
==============================

// Module: bullet_pool
// PURPOSE
//   Parametrised multi-slot projectile engine for the VGA game layer. Holds NUM_SLOTS bullets.
//   On each frame tick it runs three steps in order: erase every slot's old sprite, update
//   positions, then draw every live slot. It emits one pixel per cycle to the shared plotter.
//   Fire requests and hit reports come from the player and collision logic.
// PARAMETERS
//   NUM_SLOTS  4       bullet slots (1..8)
//   BW         2       sprite width, pixels
//   BH         4       sprite height, pixels
//   SPEED      2       rows moved upward per frame
//   X_OFS      5       spawn x = pos_x - X_OFS
//   Y_OFS      4       spawn y = pos_y - Y_OFS
//   Y_MIN      5       retire when slot y < Y_MIN (Y_MIN >= SPEED required)
//   COLOUR     3'b001  draw colour; erase colour is always 3'b000
// PORTS
//   clk        in   1          system clock
//   reset      in   1          asynchronous, active-high
//   tick       in   1          frame step pulse; ignored while busy
//   fire       in   1          spawn request pulse
//   pos_x      in   9          shooter x, sampled at UPDATE
//   pos_y      in   8          shooter y, sampled at UPDATE
//   hit        in   NUM_SLOTS  per-slot collision pulse
//   x          out  9          pixel x
//   y          out  8          pixel y
//   colour     out  3          pixel colour
//   plot       out  1          x/y/colour valid this cycle
//   busy       out  1          frame sequence in progress
//   done       out  1          1-cycle pulse, end of frame sequence
//   active     out  NUM_SLOTS  slot live flags
//   fire_drop  out  1          1-cycle pulse, fire discarded because no slot was free
// BEHAVIOUR
// - Reset: async. State=IDLE. All outputs 0. Slots inactive. Pending fire/hit cleared.
//   Reset mid-frame aborts at once; no further pixels are emitted.
// - FSM states: IDLE -> ERASE -> UPDATE -> DRAW -> DONE -> IDLE.
//   - IDLE -> ERASE on tick.
//   - ERASE/DRAW: scan slot s=0..N-1. Within each slot, row r=0..BH-1, then col c=0..BW-1.
//     One cycle per (s,r,c). P = BW*BH. Each pass takes exactly N*P cycles.
//   - The pixel is x=sx[s]+c, y=sy[s]+r (mod 2^9 / 2^8).
//   - plot=1 only if slot s was active at the start of that pass. Otherwise plot=0 and
//     x/y/colour hold their values.
//   - ERASE colour=0. DRAW colour=COLOUR.
//   - UPDATE takes 1 cycle and processes all slots in parallel:
//     a) Active slot with hit pending, or sy<Y_MIN: clear active.
//     b) Active slot otherwise: sy <= sy-SPEED.
//     c) If fire is pending, the lowest-index slot that was inactive at UPDATE entry is
//        set active with sx=pos_x-X_OFS, sy=pos_y-Y_OFS.
//     d) If fire is pending and no slot is free, pulse fire_drop.
//     All pending flags clear.
//   - A slot retired in (a) is not reusable until the next frame.
//   - A slot spawned in (c) is drawn in this frame's DRAW pass.
//   - DONE takes 1 cycle: done=1. busy drops to 0 in the same cycle, then IDLE.
// - Timing: tick sampled at cycle 0.
//   - ERASE pixels: cycles 1..N*P.
//   - UPDATE: cycle N*P+1.
//   - DRAW pixels: cycles N*P+2 .. 2N*P+1.
//   - done: cycle 2N*P+2.
//   - busy=1 on cycles 1..2N*P+1.
// - Latching:
//   - fire and hit[i] are sticky-latched on any cycle, including IDLE.
//   - A pulse coincident with the UPDATE cycle counts for that UPDATE.
//   - Multiple fires before one UPDATE collapse to one spawn.
// - tick while busy is dropped, not queued.
// - Outputs x/y/colour/plot are registered. No combinational input-to-output paths.
// TESTING
//   T1 reset mid-DRAW: assert reset -> plot=0, busy=0, active=0 immediately; next tick gives
//      no plot during ERASE.
//   T2 fire, pos=(100,200), then tick, N=4,P=8:
//      - UPDATE at cycle 33 sets active=0001.
//      - DRAW cycles 34..41 plot (95..96, 196..199), colour=001.
//      - done at cycle 66.
//   T3 four frames after T2:
//      - Each ERASE plots the old box.
//      - sy sequence is 196, 194, 192, 190.
//      - Exactly 8 plots per pass.
//   T4 fire with all 4 slots active, then tick:
//      - fire_drop pulses at UPDATE, active stays 1111.
//      - hit[2] the same frame clears bit 2, so the slot is free next frame.
//   T5 slot at sy=5 and sy=4 with SPEED=2:
//      - sy=5 moves to 3.
//      - sy=4 retires with no draw.
//      - A retire plus a fire in the same frame spawns into another free slot, never the
//        retired one.
//   T6 tick pulses while busy=1: ignored. Frame length stays 2N*P+2 and there is no second
//      done.

Source files
------------

// File: rtl/bullet_pool_if.sv
// Bullet pool bus: request inputs from player/collision logic, pixel stream and status outputs.
// Latency: n/a (signal bundle only).
// Backpressure: none; the pixel stream is one pixel per cycle with no ready.
`timescale 1ns/1ps
interface bullet_pool_if #(
    parameter int NUM_SLOTS = 4
);
    logic                 tick;
    logic                 fire;
    logic [8:0]           pos_x;
    logic [7:0]           pos_y;
    logic [NUM_SLOTS-1:0] hit;
    logic [8:0]           x;
    logic [7:0]           y;
    logic [2:0]           colour;
    logic                 plot;
    logic                 busy;
    logic                 done;
    logic [NUM_SLOTS-1:0] active;
    logic                 fire_drop;

    // Game side: issues ticks, fires and hits, consumes pixels
    modport master (
        output tick, fire, pos_x, pos_y, hit,
        input  x, y, colour, plot, busy, done, active, fire_drop
    );

    // Pool side
    modport slave (
        input  tick, fire, pos_x, pos_y, hit,
        output x, y, colour, plot, busy, done, active, fire_drop
    );
endinterface

// File: rtl/bullet_pool.sv
// Bullet pool: N-slot projectile engine; each frame erases, moves, then redraws every live bullet.
// Latency: first pixel 1 cycle after tick; frame lasts 2*N*BW*BH+2 cycles with done on the last.
// Backpressure: none; plotter takes one pixel per cycle, ticks arriving while busy are dropped.
`timescale 1ns/1ps
module bullet_pool #(
    parameter int         NUM_SLOTS = 4,
    parameter int         BW        = 2,
    parameter int         BH        = 4,
    parameter int         SPEED     = 2,
    parameter int         X_OFS     = 5,
    parameter int         Y_OFS     = 4,
    parameter int         Y_MIN     = 5,
    parameter logic [2:0] COLOUR    = 3'b001
) (
    input  logic          clk,
    input  logic          reset,
    bullet_pool_if.slave  bus
);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int RW = (BH > 1) ? $clog2(BH) : 1;
    localparam int CW = (BW > 1) ? $clog2(BW) : 1;

    typedef enum logic [2:0] {IDLE, ERASE, UPDATE, DRAW, DONE} state_t;

    state_t                     state_q;
    logic [SW-1:0]              s_q;
    logic [RW-1:0]              r_q;
    logic [CW-1:0]              c_q;
    logic [NUM_SLOTS-1:0]       act_q, act_d;
    logic [NUM_SLOTS-1:0][8:0]  sx_q, sx_d;
    logic [NUM_SLOTS-1:0][7:0]  sy_q, sy_d;
    logic                       fire_pend_q;
    logic [NUM_SLOTS-1:0]       hit_pend_q;
    logic                       fire_eff;
    logic [NUM_SLOTS-1:0]       hit_eff;
    logic                       spawned;
    logic                       drop_d;

    logic [SW-1:0]              s_nx, tgt_s;
    logic [RW-1:0]              r_nx, tgt_r;
    logic [CW-1:0]              c_nx, tgt_c;
    logic                       pass_end;
    logic                       emit;
    logic [8:0]                 pix_x;
    logic [7:0]                 pix_y;
    logic [2:0]                 pix_col;
    logic                       pix_act;

    logic [8:0]                 x_q;
    logic [7:0]                 y_q;
    logic [2:0]                 colour_q;
    logic                       plot_q, busy_q, done_q, drop_q;

    // Slot update: retire/move active slots, spawn into the first slot free at UPDATE entry
    always_comb begin
        fire_eff = fire_pend_q | bus.fire;
        hit_eff  = hit_pend_q | bus.hit;
        act_d    = act_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        spawned  = 1'b0;
        drop_d   = 1'b0;
        if (state_q == UPDATE) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (act_q[i]) begin
                    if (hit_eff[i] || (sy_q[i] < 8'(Y_MIN))) begin
                        act_d[i] = 1'b0;
                    end else begin
                        sy_d[i] = sy_q[i] - 8'(SPEED);
                    end
                end
            end
            // Freshly retired slots were active at entry, so they are never picked here
            if (fire_eff) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (!spawned && !act_q[i]) begin
                        spawned  = 1'b1;
                        act_d[i] = 1'b1;
                        sx_d[i]  = bus.pos_x - 9'(X_OFS);
                        sy_d[i]  = bus.pos_y - 8'(Y_OFS);
                    end
                end
                drop_d = !spawned;
            end
        end
    end

    // Scan counter advance: column fastest, then row, then slot
    always_comb begin
        c_nx     = c_q + CW'(1);
        r_nx     = r_q;
        s_nx     = s_q;
        pass_end = 1'b0;
        if (c_q == CW'(BW - 1)) begin
            c_nx = '0;
            if (r_q == RW'(BH - 1)) begin
                r_nx = '0;
                if (s_q == SW'(NUM_SLOTS - 1)) begin
                    s_nx     = '0;
                    pass_end = 1'b1;
                end else begin
                    s_nx = s_q + SW'(1);
                end
            end else begin
                r_nx = r_q + RW'(1);
            end
        end
    end

    // Next pixel to register; uses post-update slot state so UPDATE can preload DRAW's first pixel
    always_comb begin
        tgt_s = s_nx;
        tgt_r = r_nx;
        tgt_c = c_nx;
        if (state_q == IDLE || state_q == UPDATE) begin
            tgt_s = '0;
            tgt_r = '0;
            tgt_c = '0;
        end
        pix_x   = sx_d[tgt_s] + 9'(tgt_c);
        pix_y   = sy_d[tgt_s] + 8'(tgt_r);
        pix_act = act_d[tgt_s];
        pix_col = (state_q == UPDATE || state_q == DRAW) ? COLOUR : 3'b000;
        emit    = (state_q == IDLE && bus.tick) || (state_q == UPDATE) ||
                  ((state_q == ERASE || state_q == DRAW) && !pass_end);
    end

    // Sticky request latches, consumed by the UPDATE cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fire_pend_q <= 1'b0;
            hit_pend_q  <= '0;
        end else if (state_q == UPDATE) begin
            fire_pend_q <= 1'b0;
            hit_pend_q  <= '0;
        end else begin
            fire_pend_q <= fire_pend_q | bus.fire;
            hit_pend_q  <= hit_pend_q | bus.hit;
        end
    end

    // Frame sequencer with registered pixel and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            s_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            act_q    <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            act_q  <= act_d;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            drop_q <= drop_d;
            done_q <= 1'b0;
            plot_q <= 1'b0;
            // Inactive slots emit nothing and leave x/y/colour holding
            if (emit && pix_act) begin
                plot_q   <= 1'b1;
                x_q      <= pix_x;
                y_q      <= pix_y;
                colour_q <= pix_col;
            end
            case (state_q)
                IDLE: begin
                    if (bus.tick) begin
                        state_q <= ERASE;
                        busy_q  <= 1'b1;
                        s_q     <= '0;
                        r_q     <= '0;
                        c_q     <= '0;
                    end
                end
                ERASE: begin
                    if (pass_end) begin
                        state_q <= UPDATE;
                    end else begin
                        s_q <= s_nx;
                        r_q <= r_nx;
                        c_q <= c_nx;
                    end
                end
                UPDATE: begin
                    state_q <= DRAW;
                    s_q     <= '0;
                    r_q     <= '0;
                    c_q     <= '0;
                end
                DRAW: begin
                    if (pass_end) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        s_q <= s_nx;
                        r_q <= r_nx;
                        c_q <= c_nx;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.colour    = colour_q;
    assign bus.plot      = plot_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.active    = act_q;
    assign bus.fire_drop = drop_q;
endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: directed frames plus random frames against a per-frame slot model.
// Latency: checks every cycle of each frame from tick to two cycles past done.
// Backpressure: none; ticks are also injected while busy to confirm they are dropped.
`timescale 1ns/1ps
module tb_bullet_pool;
    localparam int N     = 4;
    localparam int BW    = 2;
    localparam int BH    = 4;
    localparam int P     = BW * BH;
    localparam int NP    = N * P;
    localparam int SPEED = 2;
    localparam int X_OFS = 5;
    localparam int Y_OFS = 4;
    localparam int Y_MIN = 5;
    localparam logic [2:0] COL = 3'b001;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [N-1:0] m_act;
    logic [8:0]   m_sx [N];
    logic [7:0]   m_sy [N];
    logic [8:0]   lx;
    logic [7:0]   ly;
    logic [2:0]   lc;

    always #5 clk = ~clk;

    bullet_pool_if #(.NUM_SLOTS(N)) bus ();

    bullet_pool #(
        .NUM_SLOTS(N), .BW(BW), .BH(BH), .SPEED(SPEED),
        .X_OFS(X_OFS), .Y_OFS(Y_OFS), .Y_MIN(Y_MIN), .COLOUR(COL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_act = '0;
        for (int i = 0; i < N; i++) begin
            m_sx[i] = '0;
            m_sy[i] = '0;
        end
        lx = '0;
        ly = '0;
        lc = '0;
    endtask

    // One frame: requests in IDLE (f_pre/h_pre) and/or on the UPDATE cycle (f_upd/h_upd)
    task automatic run_frame(input logic f_pre, input logic f_upd,
                             input logic [8:0] px, input logic [7:0] py,
                             input logic [N-1:0] h_pre, input logic [N-1:0] h_upd,
                             input logic noisy, input int abort_at, input logic t2);
        logic [N-1:0] o_act, n_act, hits;
        logic [8:0]   o_sx [N];
        logic [8:0]   n_sx [N];
        logic [7:0]   o_sy [N];
        logic [7:0]   n_sy [N];
        logic         drop, e_plot, in_pass, draw;
        logic [27:0]  got, exp;
        int           free, idx, s, r, c;

        @(negedge clk);
        bus.pos_x = px;
        bus.pos_y = py;
        bus.fire  = f_pre;
        bus.hit   = h_pre;
        @(negedge clk);
        bus.fire  = 1'b0;
        bus.hit   = '0;

        o_act = m_act; o_sx = m_sx; o_sy = m_sy;
        n_act = m_act; n_sx = m_sx; n_sy = m_sy;
        hits  = h_pre | h_upd;
        free  = -1;
        drop  = 1'b0;
        for (int i = 0; i < N; i++) if (!o_act[i] && free < 0) free = i;
        for (int i = 0; i < N; i++) begin
            if (o_act[i]) begin
                if (hits[i] || int'(o_sy[i]) < Y_MIN) n_act[i] = 1'b0;
                else n_sy[i] = o_sy[i] - 8'(SPEED);
            end
        end
        if (f_pre || f_upd) begin
            if (free >= 0) begin
                n_act[free] = 1'b1;
                n_sx[free]  = px - 9'(X_OFS);
                n_sy[free]  = py - 8'(Y_OFS);
            end else begin
                drop = 1'b1;
            end
        end

        bus.tick = 1'b1;
        @(posedge clk); #1;
        bus.tick = 1'b0;
        for (int k = 1; k <= 2*NP + 4; k++) begin
            in_pass = 1'b0;
            draw    = 1'b0;
            idx     = 0;
            if (k <= NP) begin
                in_pass = 1'b1;
                idx     = k - 1;
            end else if (k >= NP + 2 && k <= 2*NP + 1) begin
                in_pass = 1'b1;
                draw    = 1'b1;
                idx     = k - NP - 2;
            end
            s = idx / P;
            r = (idx % P) / BW;
            c = idx % BW;
            e_plot = 1'b0;
            if (in_pass && (draw ? n_act[s] : o_act[s])) begin
                e_plot = 1'b1;
                lx = (draw ? n_sx[s] : o_sx[s]) + 9'(c);
                ly = (draw ? n_sy[s] : o_sy[s]) + 8'(r);
                lc = draw ? COL : 3'b000;
            end
            exp = {(k == NP + 2) && drop, k <= 2*NP + 1, k == 2*NP + 2, e_plot,
                   (k <= NP + 1) ? o_act : n_act, lx, ly, lc};
            got = {bus.fire_drop, bus.busy, bus.done, bus.plot,
                   bus.active, bus.x, bus.y, bus.colour};
            chk($sformatf("cyc k=%0d", k), 32'(got), 32'(exp));
            if (t2 && k == 34) begin
                chk("t2_draw0", 32'({bus.plot, bus.x, bus.y, bus.colour}),
                    32'({1'b1, 9'd95, 8'd196, 3'b001}));
                chk("t2_active", 32'(bus.active), 32'(4'b0001));
            end
            if (t2 && k == 41) chk("t2_draw7", 32'({bus.x, bus.y}), 32'({9'd96, 8'd199}));
            if (t2 && k == 66) chk("t2_done66", 32'(bus.done), 32'(1));
            if (k == abort_at) begin
                #2 reset = 1'b1;
                #1;
                chk("rst_async", 32'({bus.plot, bus.busy, bus.done, bus.active}), 32'(0));
                model_clear();
                bus.fire = 1'b0;
                bus.tick = 1'b0;
                bus.hit  = '0;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            bus.fire = (k == NP + 1) ? f_upd : ((abort_at > 0 && k == NP + 3) ? 1'b1 : 1'b0);
            bus.hit  = (k == NP + 1) ? h_upd : '0;
            bus.tick = noisy && (k <= 2*NP + 1) && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        m_act = n_act;
        m_sx  = n_sx;
        m_sy  = n_sy;
    endtask

    initial begin
        reset     = 1'b1;
        bus.tick  = 1'b0;
        bus.fire  = 1'b0;
        bus.pos_x = '0;
        bus.pos_y = '0;
        bus.hit   = '0;
        model_clear();
        #12;
        chk("reset_outs", 32'({bus.x, bus.y, bus.colour, bus.plot, bus.busy,
                               bus.done, bus.active, bus.fire_drop}), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        // Single spawn at (100,200), then four frames of movement
        run_frame(1'b1, 1'b0, 9'd100, 8'd200, '0, '0, 1'b0, 0, 1'b1);
        repeat (4) run_frame(1'b0, 1'b0, 9'd0, 8'd0, '0, '0, 1'b0, 0, 1'b0);

        // Fill every slot, then fire into a full pool while slot 2 is hit
        repeat (3) run_frame(1'b1, 1'b0, 9'($urandom), 8'($urandom_range(60, 255)),
                             '0, '0, 1'b0, 0, 1'b0);
        run_frame(1'b1, 1'b0, 9'd300, 8'd150, 4'b0100, '0, 1'b0, 0, 1'b0);
        run_frame(1'b1, 1'b0, 9'd20, 8'd120, '0, '0, 1'b1, 0, 1'b0);

        // Reset mid-DRAW with a fire pending, then a frame that must stay dark
        run_frame(1'b0, 1'b0, 9'd0, 8'd0, '0, '0, 1'b0, NP + 6, 1'b0);
        run_frame(1'b0, 1'b0, 9'd50, 8'd50, '0, '0, 1'b0, 0, 1'b0);

        // Top-edge retirement and spawn avoiding the just-retired slot
        run_frame(1'b1, 1'b0, 9'd40, 8'd10, '0, '0, 1'b0, 0, 1'b0);
        run_frame(1'b1, 1'b0, 9'd60, 8'd9, '0, '0, 1'b0, 0, 1'b0);
        run_frame(1'b0, 1'b1, 9'd80, 8'd100, '0, '0, 1'b0, 0, 1'b0);
        run_frame(1'b1, 1'b0, 9'd90, 8'd110, '0, '0, 1'b1, 0, 1'b0);

        // Random frames with ticks injected while busy
        for (int f = 0; f < 24; f++) begin
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                      9'($urandom), 8'($urandom),
                      ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                      ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                      1'($urandom_range(0, 1)), 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
